// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock referee and its move counter.
package chess_clock_pkg;

    // One BCD digit as shown on a 7-segment display.
    typedef logic [3:0] bcd_t;

    // Player indices into the per-player buses.
    localparam int PLAYER_W = 0;
    localparam int PLAYER_B = 1;

    // Referee state encoding. These constants are kept so that older code keyed on
    // plain vectors still works alongside the enum view below.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN_W = 3'd1;
    localparam logic [2:0] ST_RUN_B = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RUN_W = ST_RUN_W,
        S_RUN_B = ST_RUN_B,
        S_PAUSE = ST_PAUSE,
        S_OVER  = ST_OVER
    } referee_state_e;

    // The state in which a given player's clock is running.
    function automatic logic [2:0] run_state(input int player);
        return (player == PLAYER_W) ? ST_RUN_W : ST_RUN_B;
    endfunction

endpackage

// File: rtl/chess_clock_referee_if.sv
// Player-side bus of the chess clock referee.
// The i_pause signal exists only when CHESS_CLOCK_PAUSE_EN is defined.
interface chess_clock_referee_if ();
    import chess_clock_pkg::*;

    logic       i_start;
    logic [1:0] i_turn;
    logic [1:0] i_zero;
`ifdef CHESS_CLOCK_PAUSE_EN
    logic       i_pause;
`endif
    bcd_t [1:0] o_init;
    logic       o_restart;
    logic [1:0] o_stop;
    logic [1:0] o_win;
    bcd_t [1:0] o_moves;

    // Side that drives the game (players / buttons / bench).
    modport master (
        output i_start, i_turn, i_zero,
`ifdef CHESS_CLOCK_PAUSE_EN
        output i_pause,
`endif
        input  o_init, o_restart, o_stop, o_win, o_moves
    );

    // The referee itself.
    modport slave (
        input  i_start, i_turn, i_zero,
`ifdef CHESS_CLOCK_PAUSE_EN
        input  i_pause,
`endif
        output o_init, o_restart, o_stop, o_win, o_moves
    );

endinterface

// File: rtl/chess_clock_move_counter.sv
// Two-digit BCD full-move counter: synchronous clear, saturating increment at 99.
module chess_clock_move_counter
    import chess_clock_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output bcd_t [1:0] o_moves
);

    bcd_t [1:0] count_q;
    bcd_t [1:0] count_d;
    logic       at_max;

    assign at_max = (count_q[1] == 4'd9) && (count_q[0] == 4'd9);

    // Next count: clear wins over increment; units roll into tens; hold at 99.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && !at_max) begin
            if (count_q[0] == 4'd9) begin
                count_d[0] = 4'd0;
                count_d[1] = count_q[1] + 4'd1;
            end else begin
                count_d[0] = count_q[0] + 4'd1;
            end
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_moves = count_q;

endmodule

// File: rtl/chess_clock_referee.sv
// Chess clock referee: decides whose clock runs, detects flag fall, counts full moves.
// Optional pause support is built when CHESS_CLOCK_PAUSE_EN is defined.
module chess_clock_referee
    import chess_clock_pkg::*;
#(
    parameter bcd_t p_init_tens  = 4'd1,
    parameter bcd_t p_init_units = 4'd0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    chess_clock_referee_if.slave  bus
);

    logic [2:0] state_q, state_d;
    logic [1:0] stop_q, stop_d;
    logic [1:0] win_q, win_d;
    logic       restart_q, restart_d;
    logic       moves_clr, moves_inc;
`ifdef CHESS_CLOCK_PAUSE_EN
    logic       side_q, side_d;     // 0 = white was running when paused, 1 = black
`endif

    // Game transitions. Start beats everything; flag fall beats pause and turn click.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        restart_d = 1'b0;
        moves_clr = 1'b0;
        moves_inc = 1'b0;
`ifdef CHESS_CLOCK_PAUSE_EN
        side_d    = side_q;
`endif
        if (bus.i_start) begin
            state_d   = ST_RUN_W;
            win_d     = 2'b00;
            restart_d = 1'b1;
            moves_clr = 1'b1;
        end else begin
            case (state_q)
                ST_RUN_W: begin
                    if (bus.i_zero[PLAYER_W]) begin
                        state_d = ST_OVER;
                        win_d   = 2'b10;
                    end
`ifdef CHESS_CLOCK_PAUSE_EN
                    else if (bus.i_pause) begin
                        state_d = ST_PAUSE;
                        side_d  = 1'b0;
                    end
`endif
                    else if (bus.i_turn[PLAYER_W]) begin
                        state_d = ST_RUN_B;
                    end
                end
                ST_RUN_B: begin
                    if (bus.i_zero[PLAYER_B]) begin
                        state_d = ST_OVER;
                        win_d   = 2'b01;
                    end
`ifdef CHESS_CLOCK_PAUSE_EN
                    else if (bus.i_pause) begin
                        state_d = ST_PAUSE;
                        side_d  = 1'b1;
                    end
`endif
                    else if (bus.i_turn[PLAYER_B]) begin
                        state_d   = ST_RUN_W;
                        moves_inc = 1'b1;
                    end
                end
`ifdef CHESS_CLOCK_PAUSE_EN
                ST_PAUSE: begin
                    if (bus.i_pause) begin
                        state_d = side_q ? ST_RUN_B : ST_RUN_W;
                    end
                end
`endif
                default: begin
                    // IDLE and OVER wait for a start pulse.
                end
            endcase
        end
    end

    // A player's clock runs only in that player's RUN state.
    for (genvar gi = 0; gi < 2; gi++) begin : g_stop
        assign stop_d[gi] = (state_d != run_state(gi));
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            stop_q    <= 2'b11;
            win_q     <= 2'b00;
            restart_q <= 1'b0;
`ifdef CHESS_CLOCK_PAUSE_EN
            side_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            win_q     <= win_d;
            restart_q <= restart_d;
`ifdef CHESS_CLOCK_PAUSE_EN
            side_q    <= side_d;
`endif
        end
    end

    chess_clock_move_counter u_moves (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (moves_clr),
        .i_inc   (moves_inc),
        .o_moves (bus.o_moves)
    );

    assign bus.o_init    = {p_init_tens, p_init_units};
    assign bus.o_stop    = stop_q;
    assign bus.o_win     = win_q;
    assign bus.o_restart = restart_q;

endmodule
